// File: rtl/key_step_gen.sv
// key_step_gen: synchronise and debounce an active-low key into single-cycle step pulses
// with optional auto-repeat, plus a direction flag sampled on each step.
module key_step_gen #(
  parameter int DEB_CYCLES = 500000,
  parameter int RPT_EN     = 1,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic ck_i,
  input  logic rs_i,
  input  logic key_n_i,
  input  logic dir_sw_i,
  output logic step_o,
  output logic up_o,
  output logic pressed_o
);
  localparam int M1 = DEB_CYCLES > RPT_DELAY ? DEB_CYCLES : RPT_DELAY;
  localparam int CW = $clog2(M1 > RPT_PERIOD ? M1 : RPT_PERIOD);
  localparam logic RE = RPT_EN != 0;
  typedef enum logic [2:0] {IDLE, DEB_PRESS, HOLD, REPEAT, DEB_REL} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    key_q, dir_q;
  logic          step_q, up_q, pressed_q;
  logic          key_s, dir_s, deb_end, dly_end, per_end;
  assign key_s     = ~key_q[1];
  assign dir_s     = dir_q[1];
  assign deb_end   = cnt_q == CW'(DEB_CYCLES - 1);
  assign dly_end   = cnt_q == CW'(RPT_DELAY - 1);
  assign per_end   = cnt_q == CW'(RPT_PERIOD - 1);
  assign step_o    = step_q;
  assign up_o      = up_q;
  assign pressed_o = pressed_q;
  // A repeat that fires on the same edge the key is seen released still emits its step.
  always_ff @(posedge ck_i or posedge rs_i) begin
    if (rs_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= 2'b11;
      dir_q     <= 2'b00;
      step_q    <= 1'b0;
      up_q      <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      key_q  <= {key_q[0], key_n_i};
      dir_q  <= {dir_q[0], dir_sw_i};
      step_q <= 1'b0;
      case (state_q)
        IDLE: if (key_s) begin
          state_q <= DEB_PRESS;
          cnt_q   <= '0;
        end
        DEB_PRESS: if (!key_s) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (deb_end) begin
          state_q   <= HOLD;
          cnt_q     <= '0;
          step_q    <= 1'b1;
          up_q      <= dir_s;
          pressed_q <= 1'b1;
        end else cnt_q <= cnt_q + CW'(1);
        HOLD: if (RE && dly_end) begin
          state_q <= key_s ? REPEAT : DEB_REL;
          cnt_q   <= '0;
          step_q  <= 1'b1;
          up_q    <= dir_s;
        end else if (!key_s) begin
          state_q <= DEB_REL;
          cnt_q   <= '0;
        end else if (RE) cnt_q <= cnt_q + CW'(1);
        REPEAT: if (per_end) begin
          state_q <= key_s ? REPEAT : DEB_REL;
          cnt_q   <= '0;
          step_q  <= 1'b1;
          up_q    <= dir_s;
        end else if (!key_s) begin
          state_q <= DEB_REL;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + CW'(1);
        DEB_REL: if (key_s) cnt_q <= '0;
        else if (deb_end) begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          pressed_q <= 1'b0;
        end else cnt_q <= cnt_q + CW'(1);
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_step_gen.sv
// tb_key_step_gen: directed vectors for press/hold/release timing plus bounce, direction and reset cases.
module tb_key_step_gen;
  logic ck = 1'b0, rs = 1'b1, key_n = 1'b1, dir_sw = 1'b0;
  logic step, up, pressed, step0, up0, pressed0;
  int checks = 0, failures = 0, nstep = 0, npress = 0;
  key_step_gen #(.DEB_CYCLES(4), .RPT_EN(1), .RPT_DELAY(20), .RPT_PERIOD(8)) dut (
    .ck_i(ck), .rs_i(rs), .key_n_i(key_n), .dir_sw_i(dir_sw),
    .step_o(step), .up_o(up), .pressed_o(pressed));
  key_step_gen #(.DEB_CYCLES(4), .RPT_EN(0), .RPT_DELAY(20), .RPT_PERIOD(8)) dut0 (
    .ck_i(ck), .rs_i(rs), .key_n_i(key_n), .dir_sw_i(dir_sw),
    .step_o(step0), .up_o(up0), .pressed_o(pressed0));
  always #5 ck = ~ck;
  always @(negedge ck) begin
    if (step) nstep++;
    if (pressed) npress++;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge ck);
    #1;
  endtask
  typedef struct {
    int hold; logic dir; int n; int first; int second; int last; logic upv; int n0; int drop;
  } vec_t;
  vec_t v[6];
  int n, n0, first, second, last, drop, drop0, upbad, glitch, s0, p0;
  logic was, was0, up_prev;
  initial begin
    // hold = edges sampling key_n=0; edges counted from the first such edge
    v[0] = '{10, 1'b1, 1, 7,  0,  7, 1'b1, 1, 17};
    v[1] = '{4,  1'b1, 0, 0,  0,  0, 1'b1, 0, 0};
    v[2] = '{5,  1'b0, 1, 7,  0,  7, 1'b0, 1, 12};
    v[3] = '{60, 1'b0, 6, 7, 27, 59, 1'b0, 1, 67};
    v[4] = '{24, 1'b1, 2, 7, 27, 27, 1'b1, 1, 31};
    v[5] = '{23, 1'b1, 1, 7,  0,  7, 1'b1, 1, 30};
    repeat (3) tick;
    chk("rst_step", step, 0);
    chk("rst_up", up, 0);
    chk("rst_pressed", pressed, 0);
    chk("rst_pressed0", pressed0, 0);
    rs = 1'b0;
    repeat (3) tick;
    s0 = nstep; p0 = npress;
    dir_sw = 1'b1; key_n = 1'b0;
    tick; tick; key_n = 1'b1;
    tick; key_n = 1'b0;
    tick; tick; key_n = 1'b1;
    repeat (15) tick;
    chk("bounce_steps", nstep - s0, 0);
    chk("bounce_pressed", npress - p0, 0);
    for (int i = 0; i < 6; i++) begin
      n = 0; n0 = 0; first = 0; second = 0; last = 0; drop = 0; drop0 = 0;
      upbad = 0; glitch = 0; was = 1'b0; was0 = 1'b0; up_prev = up;
      dir_sw = v[i].dir; key_n = 1'b0;
      for (int e = 1; e <= v[i].hold + 20; e++) begin
        tick;
        if (step) begin
          n++;
          if (n == 1) first = e;
          if (n == 2) second = e;
          last = e;
          if (up !== v[i].upv) upbad++;
        end else if (up !== up_prev) glitch++;
        up_prev = up;
        if (step0) n0++;
        if (pressed) was = 1'b1; else if (was && drop == 0) drop = e;
        if (pressed0) was0 = 1'b1; else if (was0 && drop0 == 0) drop0 = e;
        if (e == v[i].hold) key_n = 1'b1;
      end
      chk($sformatf("v%0d_steps", i), n, v[i].n);
      chk($sformatf("v%0d_first", i), first, v[i].first);
      chk($sformatf("v%0d_second", i), second, v[i].second);
      chk($sformatf("v%0d_last", i), last, v[i].last);
      chk($sformatf("v%0d_up_bad", i), upbad, 0);
      chk($sformatf("v%0d_up_glitch", i), glitch, 0);
      chk($sformatf("v%0d_norpt_steps", i), n0, v[i].n0);
      chk($sformatf("v%0d_pressed_seen", i), int'(was), int'(v[i].n > 0));
      chk($sformatf("v%0d_drop", i), drop, v[i].drop);
      chk($sformatf("v%0d_norpt_drop", i), drop0, v[i].drop);
      repeat (5) tick;
    end
    dir_sw = 1'b1; key_n = 1'b0;
    for (int e = 1; e <= 35; e++) begin
      tick;
      if (e == 27) begin chk("dir_step27", step, 1); chk("dir_up27", up, 1); end
      if (e == 34) begin chk("dir_step34", step, 0); chk("dir_up34", up, 1); end
      if (e == 35) begin chk("dir_step35", step, 1); chk("dir_up35", up, 0); end
      if (e == 30) dir_sw = 1'b0;
    end
    key_n = 1'b1;
    repeat (20) tick;
    dir_sw = 1'b1; key_n = 1'b0;
    for (int e = 1; e <= 35; e++) tick;
    chk("pre_rst_step", step, 1);
    chk("pre_rst_up", up, 1);
    #1 rs = 1'b1;
    #1;
    chk("async_rst_step", step, 0);
    chk("async_rst_up", up, 0);
    chk("async_rst_pressed", pressed, 0);
    @(negedge ck) rs = 1'b0;
    n = 0; first = 0;
    for (int e = 1; e <= 12; e++) begin
      tick;
      if (step) begin n++; if (n == 1) first = e; end
      if (e == 6) chk("post_rst_pressed6", pressed, 0);
      if (e == 7) begin chk("post_rst_pressed7", pressed, 1); chk("post_rst_up7", up, 1); end
    end
    chk("post_rst_steps", n, 1);
    chk("post_rst_first", first, 7);
    key_n = 1'b1;
    repeat (20) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
